// File: rtl/data_ram_arbiter.sv
// data_ram_arbiter: shares one data_ram port between the CPU data port (M0) and a secondary master (M1)
// with round-robin, a per-tenure burst limit and lock. Define ARB_PARK_CPU_EN to park the idle bus on M0.
module data_ram_arbiter #(
  parameter int MAX_BURST = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [ADDR_W-1:0]     m0_addr,
  input  logic [DATA_W/8-1:0]   m0_sel,
  input  logic [DATA_W-1:0]     m0_wdata,
  input  logic                  m0_lock,
  output logic                  m0_ack,
  output logic [DATA_W-1:0]     m0_rdata,

  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [ADDR_W-1:0]     m1_addr,
  input  logic [DATA_W/8-1:0]   m1_sel,
  input  logic [DATA_W-1:0]     m1_wdata,
  input  logic                  m1_lock,
  output logic                  m1_ack,
  output logic [DATA_W-1:0]     m1_rdata,

  output logic                  ram_ce,
  output logic                  ram_we,
  output logic [ADDR_W-1:0]     ram_addr,
  output logic [DATA_W/8-1:0]   ram_sel,
  output logic [DATA_W-1:0]     ram_wdata,
  input  logic [DATA_W-1:0]     ram_rdata,

  output logic [1:0]            owner
);

  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_e;

`ifdef ARB_PARK_CPU_EN
  localparam state_e REST_STATE = OWN0;
`else
  localparam state_e REST_STATE = IDLE;
`endif

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_owner_q, last_owner_d;

  logic             gnt0, gnt1;
  logic             own_req, own_lock, oth_req, own_idx;
  state_e           oth_state;
  logic [CNT_W-1:0] cnt_sat;

  assign gnt0  = (state_q == OWN0);
  assign gnt1  = (state_q == OWN1);
  assign owner = {gnt1, gnt0};

  // Datapath is purely combinational so a granted master gets its ack in the same cycle.
  // NOTE: every output gets a default before the if-chain so no path leaves a latch behind.
  always_comb begin
    ram_ce    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_sel   = '0;
    ram_wdata = '0;
    m0_ack    = 1'b0;
    m0_rdata  = '0;
    m1_ack    = 1'b0;
    m1_rdata  = '0;
    if (gnt0) begin
      ram_ce    = m0_req;
      ram_we    = m0_req & m0_we;
      ram_addr  = m0_addr;
      ram_sel   = m0_sel;
      ram_wdata = m0_wdata;
      m0_ack    = m0_req;
      m0_rdata  = ram_rdata;
    end else if (gnt1) begin
      ram_ce    = m1_req;
      ram_we    = m1_req & m1_we;
      ram_addr  = m1_addr;
      ram_sel   = m1_sel;
      ram_wdata = m1_wdata;
      m1_ack    = m1_req;
      m1_rdata  = ram_rdata;
    end
  end

  // Fold both tenure states into owner/other views so the transition rules are written once.
  always_comb begin
    own_idx   = gnt1;
    own_req   = gnt1 ? m1_req  : m0_req;
    own_lock  = gnt1 ? m1_lock : m0_lock;
    oth_req   = gnt1 ? m0_req  : m1_req;
    oth_state = gnt1 ? OWN0    : OWN1;
    cnt_sat   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_owner_d = last_owner_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (m0_req && m1_req) begin
          // last_owner_q==1 means M1 held the bus last, so M0 wins the tie.
          state_d = last_owner_q ? OWN0 : OWN1;
        end else if (m0_req) begin
          state_d = OWN0;
        end else if (m1_req) begin
          state_d = OWN1;
        end else begin
          state_d = REST_STATE;
        end
      end
      OWN0, OWN1: begin
        if (!own_req) begin
          cnt_d        = '0;
          last_owner_d = own_idx;
          state_d      = oth_req ? oth_state : REST_STATE;
        end else if (!own_lock && (cnt_q == CNT_MAX) && oth_req) begin
          cnt_d        = '0;
          last_owner_d = own_idx;
          state_d      = oth_state;
        end else begin
          cnt_d = cnt_sat;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      last_owner_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_owner_q <= last_owner_d;
    end
  end

endmodule

// File: tb/tb_data_ram_arbiter.sv
// tb_data_ram_arbiter: randomized and directed bench for data_ram_arbiter with a tenure-level
// reference model and its own RAM; honours ARB_PARK_CPU_EN when defined.
module tb_data_ram_arbiter;
  localparam int MAXB = 4;

`ifdef ARB_PARK_CPU_EN
  localparam int REST     = 1;
  localparam int EXP_WAIT = 0;
`else
  localparam int REST     = 0;
  localparam int EXP_WAIT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req[2], we[2], lock[2];
  logic [31:0] addr[2], wdata[2];
  logic [3:0]  sel[2];

  logic        m0_ack, m1_ack, ram_ce, ram_we;
  logic [31:0] m0_rdata, m1_rdata, ram_addr, ram_wdata, ram_rdata;
  logic [3:0]  ram_sel;
  logic [1:0]  owner;

  logic [31:0] ram_mem [64] = '{default: 32'h0};
  logic [31:0] ref_mem [64] = '{default: 32'h0};
  logic        pl_en = 1'b0;
  logic [5:0]  pl_a  = '0;
  logic [31:0] pl_d  = '0;

  int n_tests = 0;
  int n_fail  = 0;
  int m_own, m_taken, m_last;

  always #5 clk = ~clk;

  data_ram_arbiter #(.MAX_BURST(MAXB), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .m0_req(req[0]), .m0_we(we[0]), .m0_addr(addr[0]), .m0_sel(sel[0]),
    .m0_wdata(wdata[0]), .m0_lock(lock[0]), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(req[1]), .m1_we(we[1]), .m1_addr(addr[1]), .m1_sel(sel[1]),
    .m1_wdata(wdata[1]), .m1_lock(lock[1]), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .ram_ce(ram_ce), .ram_we(ram_we), .ram_addr(ram_addr), .ram_sel(ram_sel),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .owner(owner)
  );

  // Bench-side data_ram: combinational read, byte-lane synchronous write.
  assign ram_rdata = ram_mem[ram_addr[7:2]];
  always @(posedge clk) begin
    if (pl_en) begin
      ram_mem[pl_a] <= pl_d;
    end else if (ram_ce && ram_we) begin
      for (int b = 0; b < 4; b++)
        if (ram_sel[b]) ram_mem[ram_addr[7:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required finish before it");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare every DUT output with the model at the falling edge.
  task automatic half_check();
    logic        e_ce, e_we, e_a0, e_a1;
    logic [31:0] e_addr, e_wd, e_rd0, e_rd1;
    logic [3:0]  e_sel;
    logic [1:0]  e_own;
    int          n;
    @(negedge clk);
    e_ce = 0; e_we = 0; e_a0 = 0; e_a1 = 0;
    e_addr = 0; e_wd = 0; e_rd0 = 0; e_rd1 = 0; e_sel = 0; e_own = 0;
    if (!rst && m_own != 0) begin
      n      = m_own - 1;
      e_ce   = req[n];
      e_we   = req[n] & we[n];
      e_addr = addr[n];
      e_sel  = sel[n];
      e_wd   = wdata[n];
      e_own  = (m_own == 1) ? 2'b01 : 2'b10;
      if (n == 0) begin
        e_a0  = req[0];
        e_rd0 = ref_mem[addr[0][7:2]];
      end else begin
        e_a1  = req[1];
        e_rd1 = ref_mem[addr[1][7:2]];
      end
    end
    check("ram_ce",    ram_ce,    e_ce);
    check("ram_we",    ram_we,    e_we);
    check("ram_addr",  ram_addr,  e_addr);
    check("ram_sel",   ram_sel,   e_sel);
    check("ram_wdata", ram_wdata, e_wd);
    check("m0_ack",    m0_ack,    e_a0);
    check("m1_ack",    m1_ack,    e_a1);
    check("m0_rdata",  m0_rdata,  e_rd0);
    check("m1_rdata",  m1_rdata,  e_rd1);
    check("owner",     owner,     e_own);
  endtask

  // Advance the model across a rising edge: commit the granted write, then apply tenure rules.
  task automatic advance();
    int n, o;
    @(posedge clk);
    if (rst) begin
      m_own = 0; m_taken = 0; m_last = 1;
    end else begin
      if (m_own != 0) begin
        n = m_own - 1;
        if (req[n] && we[n])
          for (int b = 0; b < 4; b++)
            if (sel[n][b]) ref_mem[addr[n][7:2]][8*b +: 8] = wdata[n][8*b +: 8];
      end
      if (m_own == 0) begin
        if (req[0] && req[1]) m_own = (m_last == 1) ? 1 : 2;
        else if (req[0])      m_own = 1;
        else if (req[1])      m_own = 2;
        else                  m_own = REST;
        m_taken = 0;
      end else begin
        n = m_own - 1;
        o = 1 - n;
        if (!req[n]) begin
          m_last  = n;
          m_taken = 0;
          m_own   = req[o] ? o + 1 : REST;
        end else begin
          m_taken++;
          if (!lock[n] && m_taken >= MAXB && req[o]) begin
            m_own = o + 1; m_taken = 0; m_last = n;
          end
        end
      end
    end
    #1;
  endtask

  task automatic idle_cycle();
    half_check();
    advance();
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    pl_en = 1'b1; pl_a = a[7:2]; pl_d = d;
    ref_mem[a[7:2]] = d;
    idle_cycle();
    pl_en = 1'b0;
  endtask

  // One beat from master m; reports wait cycles before ack and the read data seen at the ack.
  task automatic access(input int m, input logic w, input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] d, output logic [31:0] rd, output int waits);
    req[m] = 1'b1; we[m] = w; addr[m] = a; sel[m] = s; wdata[m] = d;
    waits = -1; rd = '0;
    for (int i = 0; i < 8; i++) begin
      half_check();
      if ((m == 0) ? m0_ack : m1_ack) begin
        waits = i;
        rd = (m == 0) ? m0_rdata : m1_rdata;
        advance();
        break;
      end
      advance();
    end
    req[m] = 1'b0; we[m] = 1'b0;
    check("access_acked", logic'(waits >= 0), 1'b1);
    idle_cycle();
  endtask

  initial begin
    logic [31:0] rd;
    int          w, got, cnt;
    int          exp_own [13] = '{0, 1, 1, 1, 1, 2, 2, 2, 2, 1, 1, 1, 1};

    for (int m = 0; m < 2; m++) begin
      req[m] = 0; we[m] = 0; lock[m] = 0; addr[m] = 0; wdata[m] = 0; sel[m] = 0;
    end
    m_own = 0; m_taken = 0; m_last = 1;
    rst = 1'b1;
    #1;
    check("reset_ram_ce", ram_ce, 1'b0);
    check("reset_owner",  owner,  2'b00);
    check("reset_acks",   {m0_ack, m1_ack}, 2'b00);
    advance();
    advance();

    // Simultaneous requests straight out of reset: M0 first, then 4/4 alternation.
    req[0] = 1; req[1] = 1; addr[0] = 32'h40; addr[1] = 32'h44; sel[0] = 4'hF; sel[1] = 4'hF;
    rst = 1'b0;
    for (int c = 0; c < 13; c++) begin
      half_check();
      check("t3_m0_ack", m0_ack, logic'(exp_own[c] == 1));
      check("t3_m1_ack", m1_ack, logic'(exp_own[c] == 2));
      advance();
    end
    req[0] = 0; req[1] = 0;
    idle_cycle();
    idle_cycle();

    // M1 locked: keeps the bus for 10 beats while M0 also requests.
    req[1] = 1; lock[1] = 1; addr[1] = 32'h48;
    got = 0;
    for (int i = 0; i < 6; i++) begin
      half_check();
      if (m1_ack) begin got = 1; break; end
      advance();
    end
    check("t4_m1_granted", got, 1);
    advance();
    req[0] = 1; addr[0] = 32'h4C;
    for (int i = 0; i < 10; i++) begin
      half_check();
      check("t4_m1_ack", m1_ack, 1'b1);
      check("t4_m0_ack", m0_ack, 1'b0);
      advance();
    end
    req[1] = 0; lock[1] = 0;
    half_check();
    check("t4_m0_wait", m0_ack, 1'b0);
    advance();
    half_check();
    check("t4_m0_after", m0_ack, 1'b1);
    advance();
    req[0] = 0;
    idle_cycle();
    idle_cycle();

    // Reset in the middle of an acked write: ce drops at once and the word survives.
    preload(32'h30, 32'h55555555);
    req[0] = 1; we[0] = 1; addr[0] = 32'h30; wdata[0] = 32'hCAFEF00D; sel[0] = 4'hF;
    got = 0;
    for (int i = 0; i < 6; i++) begin
      half_check();
      if (m0_ack) begin got = 1; break; end
      advance();
    end
    check("t1_acked", got, 1);
    #1 rst = 1'b1;
    #1;
    check("t1_ram_ce", ram_ce, 1'b0);
    check("t1_owner",  owner,  2'b00);
    advance();
    rst = 1'b0; req[0] = 0; we[0] = 0;
    idle_cycle();
    access(0, 1'b0, 32'h30, 4'hF, 32'h0, rd, w);
    check("t1_word_kept", rd, 32'h55555555);

    // Write then read via M0; wait count also shows the parked/unparked latency.
    access(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, rd, w);
    check("t2_wr_wait", w, EXP_WAIT);
    access(0, 1'b0, 32'h10, 4'hF, 32'h0, rd, w);
    check("t2_rd_wait", w, EXP_WAIT);
    check("t2_rdata", rd, 32'hDEADBEEF);

    // Byte-lane write from M1 read back through M0.
    preload(32'h20, 32'h11223344);
    access(1, 1'b1, 32'h20, 4'b0010, 32'h0000AB00, rd, w);
    access(0, 1'b0, 32'h20, 4'hF, 32'h0, rd, w);
    check("t5_wait", w, EXP_WAIT);
    check("t5_rdata", rd, 32'h1122AB44);

    // Randomized traffic against the model.
    cnt = 0;
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 499) == 0);
      for (int m = 0; m < 2; m++) begin
        req[m]   = ($urandom_range(0, 9) < 7);
        we[m]    = $urandom_range(0, 1);
        lock[m]  = ($urandom_range(0, 9) == 0);
        addr[m]  = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
        sel[m]   = 4'($urandom);
        wdata[m] = $urandom;
      end
      idle_cycle();
      cnt++;
    end
    rst = 1'b0;
    for (int m = 0; m < 2; m++) begin
      req[m] = 0; lock[m] = 0;
    end
    idle_cycle();
    check("random_cycles", cnt, 3000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
